// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants and types for the vectoring-mode CORDIC:
//               arctangent table, pi constants, gain correction factor and
//               the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Fractional bits the constants below are stored with.
  localparam int CORDIC_FRAC = 20;
  // Angle format of the table and the pi constants: signed 3.20.
  localparam int ANGLE_WIDTH = 23;
  // Table covers every value a 4-bit iteration index can take.
  localparam int ROM_DEPTH = 16;

  typedef logic signed [ANGLE_WIDTH-1:0] angle_t;

  // atan(2^-i) in radians, signed 3.20, rounded to nearest.
  localparam angle_t ATAN_ROM [ROM_DEPTH] = '{
    23'sh0C90FE, 23'sh076B1A, 23'sh03EB6F, 23'sh01FD5C,
    23'sh00FFAB, 23'sh007FF5, 23'sh003FFF, 23'sh002000,
    23'sh001000, 23'sh000800, 23'sh000400, 23'sh000200,
    23'sh000100, 23'sh000080, 23'sh000040, 23'sh000020
  };

  localparam angle_t PI   = 23'sh3243F7;
  localparam angle_t PI_2 = 23'sh1921FB;

  // Reciprocal of the CORDIC gain (0.607253), unsigned 0.20.
  localparam logic [CORDIC_FRAC-1:0] K_INV = 20'h9B74E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    GAIN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_vectoring_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vectoring_iter_if
// Description : Multi-cycle custom-instruction handshake (clk_en/start/done)
//               plus operand and result buses of the vectoring CORDIC.
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_vectoring_iter_if #(
  parameter int DATA_WIDTH = 22
);

  logic                         clk_en;
  logic                         start;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic signed [DATA_WIDTH:0]   angle;
  logic        [DATA_WIDTH+1:0] magnitude;
  logic                         done;
  logic                         busy;

  // Processor side: issues the instruction and collects the result.
  modport master (
    output clk_en, start, x_in, y_in,
    input  angle, magnitude, done, busy
  );

  // CORDIC side.
  modport slave (
    input  clk_en, start, x_in, y_in,
    output angle, magnitude, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vec_stage
// Description : One combinational vectoring micro-rotation. Rotates (x, y)
//               toward the positive x axis by atan(2^-i) and accumulates the
//               rotated angle into z.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 22,
  parameter int FRAC_WIDTH = 20,
  parameter int ITER_WIDTH = 4
) (
  input  logic signed [DATA_WIDTH+1:0] i_x,
  input  logic signed [DATA_WIDTH+1:0] i_y,
  input  logic signed [DATA_WIDTH:0]   i_z,
  input  logic        [ITER_WIDTH-1:0] i_iter,
  output logic signed [DATA_WIDTH+1:0] o_x,
  output logic signed [DATA_WIDTH+1:0] o_y,
  output logic signed [DATA_WIDTH:0]   o_z
);

  logic signed [DATA_WIDTH+1:0] w_x_sh;
  logic signed [DATA_WIDTH+1:0] w_y_sh;
  logic signed [DATA_WIDTH:0]   w_atan;

  assign w_x_sh = i_x >>> i_iter;
  assign w_y_sh = i_y >>> i_iter;
  // Table is stored at CORDIC_FRAC bits; realign when the ports carry fewer.
  assign w_atan = (DATA_WIDTH+1)'(ATAN_ROM[i_iter] >>> (CORDIC_FRAC - FRAC_WIDTH));

  // y below the axis rotates counter-clockwise (d=+1), otherwise clockwise;
  // sums wrap in the register width since the worst-case growth fits.
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (i_y[DATA_WIDTH+1]) begin
      o_x = i_x - w_y_sh;
      o_y = i_y + w_x_sh;
      o_z = i_z - w_atan;
    end else begin
      o_x = i_x + w_y_sh;
      o_y = i_y - w_x_sh;
      o_z = i_z + w_atan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring_iter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vectoring_iter
// Description : Iterative vectoring-mode CORDIC returning atan2(y, x) (3.20)
//               and magnitude (4.20), one micro-rotation per clock, behind
//               the clk_en/start/done custom-instruction handshake.
//               Build option CORDIC_VEC_GAIN_COMP_EN adds a GAIN state that
//               scales the magnitude by 1/K so it carries the true length.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH   = 22,
  parameter int FRAC_WIDTH   = 20,
  parameter int CORDIC_DEPTH = 15,
  parameter int ITER_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_vectoring_iter_if.slave  bus
);

  localparam int XW = DATA_WIDTH + 2;
  localparam int ZW = DATA_WIDTH + 1;
  localparam logic signed [ZW-1:0] c_pi_2 = ZW'(PI_2 >>> (CORDIC_FRAC - FRAC_WIDTH));
  localparam logic [ITER_WIDTH-1:0] c_last_iter = ITER_WIDTH'(CORDIC_DEPTH - 1);

  state_t                  r_state, w_state_n;
  logic signed [XW-1:0]    r_x, w_x_n;
  logic signed [XW-1:0]    r_y, w_y_n;
  logic signed [ZW-1:0]    r_z, w_z_n;
  logic [ITER_WIDTH-1:0]   r_i, w_i_n;
  logic                    r_zero, w_zero_n;
  logic signed [ZW-1:0]    r_angle, w_angle_n;
  logic [XW-1:0]           r_mag, w_mag_n;
  logic                    r_done, w_done_n;
  logic                    r_busy, w_busy_n;

  logic signed [XW-1:0]    w_x_ext, w_y_ext;
  logic signed [XW-1:0]    w_pre_x, w_pre_y;
  logic signed [ZW-1:0]    w_pre_z;
  logic signed [XW-1:0]    w_rot_x, w_rot_y;
  logic signed [ZW-1:0]    w_rot_z;

  assign w_x_ext = {{2{bus.x_in[DATA_WIDTH-1]}}, bus.x_in};
  assign w_y_ext = {{2{bus.y_in[DATA_WIDTH-1]}}, bus.y_in};

  // Quadrant pre-rotation by +/-90 degrees brings the vector into the right
  // half-plane, where the micro-rotations converge.
  always_comb begin
    w_pre_x = w_x_ext;
    w_pre_y = w_y_ext;
    w_pre_z = '0;
    if (w_x_ext[XW-1]) begin
      if (!w_y_ext[XW-1]) begin
        w_pre_x = w_y_ext;
        w_pre_y = -w_x_ext;
        w_pre_z = c_pi_2;
      end else begin
        w_pre_x = -w_y_ext;
        w_pre_y = w_x_ext;
        w_pre_z = -c_pi_2;
      end
    end
  end

  cordic_vec_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .ITER_WIDTH (ITER_WIDTH)
  ) u_stage (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_iter (r_i),
    .o_x    (w_rot_x),
    .o_y    (w_rot_y),
    .o_z    (w_rot_z)
  );

`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic signed [XW+CORDIC_FRAC:0] w_gain_full;
  logic signed [XW-1:0]           w_gain_x;
  assign w_gain_full = r_x * $signed({1'b0, K_INV});
  // Truncate the 4.40 product back to 4.20.
  assign w_gain_x    = w_gain_full[CORDIC_FRAC +: XW];
`endif

  // Controller: next state and next register values; everything holds
  // unless a state explicitly updates it, and done defaults to low.
  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_z_n     = r_z;
    w_i_n     = r_i;
    w_zero_n  = r_zero;
    w_angle_n = r_angle;
    w_mag_n   = r_mag;
    w_done_n  = 1'b0;
    w_busy_n  = r_busy;
    case (r_state)
      IDLE: begin
        if (bus.clk_en && bus.start) begin
          w_x_n     = w_pre_x;
          w_y_n     = w_pre_y;
          w_z_n     = w_pre_z;
          w_i_n     = '0;
          w_zero_n  = (w_x_ext == '0) && (w_y_ext == '0);
          w_busy_n  = 1'b1;
          w_state_n = ITER;
        end
      end
      ITER: begin
        if (!bus.clk_en) begin
          w_busy_n  = 1'b0;
          w_state_n = IDLE;
        end else begin
          w_x_n = w_rot_x;
          w_y_n = w_rot_y;
          w_z_n = w_rot_z;
          if (r_i == c_last_iter) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
            w_state_n = GAIN;
`else
            w_state_n = DONE;
`endif
          end else begin
            w_i_n = r_i + 1'b1;
          end
        end
      end
`ifdef CORDIC_VEC_GAIN_COMP_EN
      GAIN: begin
        if (!bus.clk_en) begin
          w_busy_n  = 1'b0;
          w_state_n = IDLE;
        end else begin
          w_x_n     = w_gain_x;
          w_state_n = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.clk_en) begin
          // A zero vector never steers d, so z would collect the whole
          // table; its angle is defined as 0 instead.
          w_angle_n = r_zero ? '0 : r_z;
          w_mag_n   = r_x;
          w_done_n  = 1'b1;
        end
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
      end
      default: begin
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
      end
    endcase
  end

  // State, datapath and result registers; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_zero  <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_z     <= w_z_n;
      r_i     <= w_i_n;
      r_zero  <= w_zero_n;
      r_angle <= w_angle_n;
      r_mag   <= w_mag_n;
      r_done  <= w_done_n;
      r_busy  <= w_busy_n;
    end
  end

  assign bus.angle     = r_angle;
  assign bus.magnitude = r_mag;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_vectoring_iter
// Description : Self-checking bench for cordic_vectoring_iter. Expected angle
//               and magnitude come from real-valued atan2/sqrt times the
//               ideal CORDIC gain (or 1.0 when CORDIC_VEC_GAIN_COMP_EN is
//               defined), compared within a tolerance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vectoring_iter;

  localparam int DW    = 22;
  localparam int FW    = 20;
  localparam int DEPTH = 15;
  localparam int IW    = 4;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int LAT = DEPTH + 2;
`else
  localparam int LAT = DEPTH + 1;
`endif
  localparam real ONE     = 1048576.0;
  localparam real PI_LSB  = 3.14159265358979 * 1048576.0;
  // Residual angle after 15 steps is bounded by atan(2^-14) ~ 64 LSB.
  localparam real ANG_TOL = 80.0;
  localparam real MAG_TOL = 48.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  real  gain;

  cordic_vectoring_iter_if #(.DATA_WIDTH(DW)) bus ();

  cordic_vectoring_iter #(
    .DATA_WIDTH   (DW),
    .FRAC_WIDTH   (FW),
    .CORDIC_DEPTH (DEPTH),
    .ITER_WIDTH   (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input real obs, input real exp,
                            input real tol, input bit wrap);
    real d;
    d = obs - exp;
    if (wrap) begin
      if (d > PI_LSB) d = d - 2.0 * PI_LSB;
      else if (d < -PI_LSB) d = d + 2.0 * PI_LSB;
    end
    checks++;
    assert ((d <= tol) && (d >= -tol)) else begin
      errors++;
      $error("FAIL %s: observed %0f expected %0f (tol %0f)", tag, obs, exp, tol);
    end
  endtask

  // Issue one instruction; operands are scrambled afterwards to show they
  // were captured at acceptance.
  task automatic start_op(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
    bus.x_in  = x;
    bus.y_in  = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.x_in  = DW'($urandom);
    bus.y_in  = DW'($urandom);
    check_eq("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Wait for done (bounded), then compare latency and result to the model.
  task automatic wait_done(input string tag, input int n0,
                           input logic signed [DW-1:0] x, input logic signed [DW-1:0] y,
                           input bit wrap);
    int  n;
    real ea, em, xr, yr;
    n = n0;
    while (bus.done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    xr = real'(x);
    yr = real'(y);
    ea = $atan2(yr, xr) * ONE;
    em = $sqrt(xr * xr + yr * yr) * gain;
    check_eq({tag, "_latency"}, 64'(n), 64'(LAT));
    check_eq({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    check_near({tag, "_angle"}, real'(bus.angle), ea, ANG_TOL, wrap);
    check_near({tag, "_mag"}, real'(bus.magnitude), em, MAG_TOL, 1'b0);
  endtask

  task automatic pick(output logic signed [DW-1:0] x, output logic signed [DW-1:0] y);
    int xi, yi;
    x = '0;
    y = '0;
    for (int t = 0; t < 100; t++) begin
      x  = DW'($urandom);
      y  = DW'($urandom);
      xi = int'(x);
      yi = int'(y);
      if (xi > 32'sh40000 || xi < -32'sh40000 || yi > 32'sh40000 || yi < -32'sh40000) break;
    end
  endtask

  initial begin
    logic signed [DW-1:0] px, py, nx, ny;
    int pulses;

    gain = 1.0;
`ifndef CORDIC_VEC_GAIN_COMP_EN
    for (int i = 0; i < DEPTH; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`endif

    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.x_in   = '0;
    bus.y_in   = '0;
    repeat (3) tick();
    check_eq("reset_angle", 64'(bus.angle), 64'd0);
    check_eq("reset_mag",   64'(bus.magnitude), 64'd0);
    check_eq("reset_done",  64'(bus.done), 64'd0);
    check_eq("reset_busy",  64'(bus.busy), 64'd0);
    rst = 1'b0;
    tick();

    // Directed vectors on the axes and the diagonal.
    start_op(22'sh100000, 22'sh000000);
    wait_done("x1y0", 0, 22'sh100000, 22'sh000000, 1'b1);
    tick();
    start_op(22'sh100000, 22'sh100000);
    wait_done("x1y1", 0, 22'sh100000, 22'sh100000, 1'b1);
    tick();
    // atan2(0,-1) must come out as +pi, so no wrap-around allowance.
    start_op(-22'sh100000, 22'sh000000);
    wait_done("xm1y0", 0, -22'sh100000, 22'sh000000, 1'b0);
    tick();
    start_op(22'sh000000, -22'sh100000);
    wait_done("x0ym1", 0, 22'sh000000, -22'sh100000, 1'b1);

    // Zero vector, then back-to-back start in its done cycle.
    start_op(22'sh000000, 22'sh000000);
    wait_done("zero", 0, 22'sh000000, 22'sh000000, 1'b1);
    check_eq("zero_angle_exact", 64'(bus.angle), 64'd0);
    check_eq("zero_mag_exact",   64'(bus.magnitude), 64'd0);
    start_op(22'sh000000, 22'sh100000);
    check_eq("b2b_done_cleared", 64'(bus.done), 64'd0);
    wait_done("b2b_x0y1", 0, 22'sh000000, 22'sh100000, 1'b1);

    // Abort with clk_en low at iteration 5: outputs stay at the zero result.
    tick();
    start_op(22'sh000000, 22'sh000000);
    wait_done("zero2", 0, 22'sh000000, 22'sh000000, 1'b1);
    start_op(22'sh100000, 22'sh100000);
    repeat (5) tick();
    bus.clk_en = 1'b0;
    tick();
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_done", 64'(bus.done), 64'd0);
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    bus.clk_en = 1'b1;
    check_eq("abort_no_done", 64'(pulses), 64'd0);
    check_eq("abort_angle_kept", 64'(bus.angle), 64'd0);
    check_eq("abort_mag_kept",   64'(bus.magnitude), 64'd0);

    // Start pulse during ITER is ignored: one done, original operands.
    tick();
    start_op(-22'sh180000, 22'sh0B3333);
    repeat (4) tick();
    bus.x_in  = 22'sh04CCCD;
    bus.y_in  = -22'sh1E6666;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("midstart", 5, -22'sh180000, 22'sh0B3333, 1'b1);
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check_eq("midstart_single_done", 64'(pulses), 64'd0);

    // Reset during ITER clears the previous (non-zero) result.
    start_op(22'sh080000, 22'sh080000);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_angle", 64'(bus.angle), 64'd0);
    check_eq("midrst_mag",   64'(bus.magnitude), 64'd0);
    check_eq("midrst_done",  64'(bus.done), 64'd0);
    check_eq("midrst_busy",  64'(bus.busy), 64'd0);
    rst = 1'b0;
    tick();
    start_op(-22'sh0CCCCD, -22'sh133333);
    wait_done("after_rst", 0, -22'sh0CCCCD, -22'sh133333, 1'b1);

    // Random operands, alternating back-to-back and gapped issue.
    pick(px, py);
    tick();
    start_op(px, py);
    for (int k = 0; k < 12; k++) begin
      wait_done($sformatf("rnd%0d", k), 0, px, py, 1'b1);
      if (k < 11) begin
        pick(nx, ny);
        if (k % 2 == 1) repeat (3) tick();
        start_op(nx, ny);
        px = nx;
        py = ny;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
